// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
package seg_scan_ctrl_pkg;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [0:6] BLANK_GLYPH = 7'b1111111;
  localparam int         NUM_DIGITS  = 4;

endpackage

// File: rtl/bcd7seg.sv
// Hex nibble to seven-segment decoder; active-high segments, seg[0:6] = a..g.
module bcd7seg (
  input  logic [3:0] hex,
  output logic [0:6] seg
);

  always_comb begin
    unique case (hex)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed four-digit display scanner with anti-ghosting guard gaps,
// double-buffered display value and leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [0:6]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int         CNT_MAX  = (PRESCALE > GUARD) ? PRESCALE : GUARD;
  localparam int         CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_end;

  logic [15:0]   shadow_val, active_val;
  logic [3:0]    shadow_dp, active_dp;
  logic          shadow_full;

  logic [3:0]    nib;
  logic [0:6]    glyph;
  logic          upper_zero, blank;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + CW'(1);
    frame_end = 1'b0;
    unique case (state_q)
      ST_GUARD: if (cnt_q == CW'(GUARD - 1)) begin
        state_d = ST_SHOW;
        cnt_d   = '0;
      end
      ST_SHOW: if (cnt_q == CW'(PRESCALE - 1)) begin
        state_d   = ST_GUARD;
        idx_d     = idx_q + 2'd1;
        cnt_d     = '0;
        frame_end = (idx_q == LAST_IDX);
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_GUARD;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are derived from the next state so segments and anode switch on one edge.
  always_comb begin
    nib = active_val[{idx_d, 2'b00} +: 4];
    unique case (idx_d)
      2'd3:    upper_zero = (active_val[15:12] == 4'h0);
      2'd2:    upper_zero = (active_val[15:8]  == 8'h00);
      2'd1:    upper_zero = (active_val[15:4]  == 12'h000);
      default: upper_zero = 1'b0;
    endcase
    blank = lz_blank && upper_zero && !active_dp[idx_d];
  end

  bcd7seg u_dec (
    .hex (nib),
    .seg (glyph)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= BLANK_GLYPH;
      dp  <= 1'b1;
    end else if (state_d == ST_SHOW && !blank) begin
      an  <= ~(4'b0001 << idx_d);
      seg <= ~glyph;
      dp  <= ~active_dp[idx_d];
    end else begin
      an  <= 4'b1111;
      seg <= BLANK_GLYPH;
      dp  <= 1'b1;
    end
  end

  // NOTE: the data registers are reset too, because the display must show 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_full <= 1'b0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
      active_val  <= '0;
      active_dp   <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (wr_valid && !shadow_full) begin
        shadow_val  <= wr_data;
        shadow_dp   <= wr_dp;
        shadow_full <= 1'b1;
      end else if (frame_end && shadow_full) begin
        active_val  <= shadow_val;
        active_dp   <= shadow_dp;
        shadow_full <= 1'b0;
      end
    end
  end

  assign wr_ready = ~shadow_full;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl against a frame-arithmetic reference model.
module tb_seg_scan_ctrl;

  localparam int P = 4;
  localparam int G = 2;
  localparam int F = 4 * (P + G);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        lz_blank = 1'b0;
  logic [15:0] wr_data = '0;
  logic [3:0]  wr_dp = '0;
  logic        wr_ready, dp, frame_done;
  logic [3:0]  an;
  logic [0:6]  seg;

  int total = 0;
  int bad   = 0;

  // Reference model state: cycles since reset release, displayed and pending values.
  int          t = 0;
  logic [15:0] m_val = '0, sh_val = '0;
  logic [3:0]  m_dp = '0, sh_dp = '0;
  logic        m_pend = 1'b0, m_lz = 1'b0;

  string glyphs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  always #5 clk = ~clk;

  seg_scan_ctrl #(.PRESCALE(P), .GUARD(G)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .lz_blank   (lz_blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d: got %h expected %h", tag, t, act, exp);
    end
  endtask

  // Active-low glyph built from the list of lit segment letters.
  function automatic logic [0:6] lit_glyph(input logic [3:0] n);
    string      s = glyphs[n];
    logic [0:6] g = '1;
    for (int i = 0; i < s.len(); i++) g[int'(s[i]) - 97] = 1'b0;
    return g;
  endfunction

  task automatic check_outputs();
    int          q, d, r;
    logic [3:0]  e_an = 4'hF;
    logic [0:6]  e_seg = '1;
    logic        e_dp = 1'b1;
    logic [15:0] upper;
    q = t % F;
    d = q / (P + G);
    r = q % (P + G);
    if (r >= G) begin
      upper = m_val >> (4 * d);
      if (!(m_lz && d > 0 && upper == 16'h0 && !m_dp[d])) begin
        e_an  = ~(4'b0001 << d);
        e_seg = lit_glyph(upper[3:0]);
        e_dp  = ~m_dp[d];
      end
    end
    check("an", {12'd0, an}, {12'd0, e_an});
    check("seg", {9'd0, seg}, {9'd0, e_seg});
    check("dp", {15'd0, dp}, {15'd0, e_dp});
    check("frame_done", {15'd0, frame_done}, {15'd0, (t > 0 && q == 0)});
    check("wr_ready", {15'd0, wr_ready}, {15'd0, !m_pend});
  endtask

  // One clock cycle: check at the falling edge, drive inputs, model the rising edge.
  task automatic step(input logic v, input logic [15:0] dat, input logic [3:0] dpb, input logic lz);
    logic was;
    check_outputs();
    wr_valid = v;
    wr_data  = dat;
    wr_dp    = dpb;
    lz_blank = lz;
    @(posedge clk);
    was  = m_pend;
    m_lz = lz;
    t++;
    if (v && !was) begin
      m_pend = 1'b1;
      sh_val = dat;
      sh_dp  = dpb;
    end else if (was && (t % F == 0)) begin
      m_val  = sh_val;
      m_dp   = sh_dp;
      m_pend = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic lz);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, lz);
  endtask

  task automatic write_val(input logic [15:0] dat, input logic [3:0] dpb, input logic lz);
    logic done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      done = !m_pend;
      step(1'b1, dat, dpb, lz);
    end
    if (!done) check("write_timeout", 16'd0, 16'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_an", {12'd0, an}, 16'h000F);
    check("rst_seg", {9'd0, seg}, 16'h007F);
    check("rst_dp", {15'd0, dp}, 16'h0001);
    check("rst_frame_done", {15'd0, frame_done}, 16'h0000);
    check("rst_wr_ready", {15'd0, wr_ready}, 16'h0001);
    wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    t      = 0;
    m_val  = '0;
    m_dp   = '0;
    m_pend = 1'b0;
    m_lz   = 1'b0;
  endtask

  initial begin
    logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    logic [15:0] offer_val;
    logic [3:0]  offer_dp;
    logic        lz, v, was;
    int          guard_cnt;

    do_reset();
    idle(2 * F + 3, 1'b0);

    // Mid-digit-1 write, then a different value offered while the shadow is full.
    while ((t % F) != P + G + G + 1) step(1'b0, 16'h0, 4'h0, 1'b0);
    write_val(16'h12AF, 4'h0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 16'hBEEF, 4'hF, 1'b0);
    idle(2 * F, 1'b0);

    // Leading-zero blanking, with and without a decimal point on digit 2.
    write_val(16'h0050, 4'b0000, 1'b1);
    idle(2 * F, 1'b1);
    write_val(16'h0050, 4'b0100, 1'b1);
    idle(2 * F, 1'b1);

    // Randomized traffic: the writer holds each offer until the model accepts it.
    offer_val = $urandom & masks[$urandom_range(0, 4)];
    offer_dp  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    lz = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 97 == 0) lz = 1'($urandom);
      v   = ($urandom_range(0, 7) == 0);
      was = m_pend;
      step(v, m_pend ? 16'($urandom) : offer_val, offer_dp, lz);
      if (v && !was) begin
        offer_val = $urandom & masks[$urandom_range(0, 4)];
        offer_dp  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      end
    end

    // Reset during SHOW of digit 2 with a value still pending in the shadow.
    idle(F, 1'b0);
    while ((t % F) != 0) step(1'b0, 16'h0, 4'h0, 1'b0);
    write_val(16'hA5C3, 4'h3, 1'b0);
    guard_cnt = 0;
    while (!((t % F) / (P + G) == 2 && (t % F) % (P + G) >= G + 1 && m_pend) && guard_cnt < 200) begin
      step(1'b0, 16'h0, 4'h0, 1'b0);
      guard_cnt++;
    end
    if (guard_cnt >= 200) check("reach_digit2_timeout", 16'd0, 16'd1);
    do_reset();
    idle(2 * F, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
